// File: rtl/apb_mux_pkg.sv
// Shared types and constants for the APB slave multiplexer and its error log.
package apb_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DECERR = 2'd2,
        ABORT  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_DEC  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;
    localparam logic [1:0] ERR_SLV  = 2'b11;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

    // A single slave still needs a one-bit index so that nonzero upper bits decode as an error.
    function automatic int idx_width(input int slv_cnt);
        return (slv_cnt <= 1) ? 1 : clog2(slv_cnt);
    endfunction

endpackage

// File: rtl/apb_err_log.sv
// Sticky first-error record: captures code and address only while empty; clear beats capture.
module apb_err_log
    import apb_mux_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  capture,
    input  logic [1:0]            code,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  err_valid,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH-1:0] err_addr
);

    logic                  valid_reg;
    logic [1:0]            code_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            code_reg  <= ERR_NONE;
            addr_reg  <= '0;
        end else if (clr) begin
            valid_reg <= 1'b0;
            code_reg  <= ERR_NONE;
            addr_reg  <= '0;
        end else if (capture && !valid_reg) begin
            valid_reg <= 1'b1;
            code_reg  <= code;
            addr_reg  <= addr;
        end
    end

    assign err_valid = valid_reg;
    assign err_code  = code_reg;
    assign err_addr  = addr_reg;

endmodule

// File: rtl/apb_slave_mux.sv
// APB4 decoder/multiplexer: routes one upstream master to up to 16 slaves and
// answers decode errors and access timeouts on its own.
module apb_slave_mux
    import apb_mux_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int SLV_ADDR_WIDTH = 8,
    parameter int SLV_CNT        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [ADDR_WIDTH-1:0]         PADDR,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic                          PWRITE,
    input  logic [DATA_WIDTH-1:0]         PWDATA,
    input  logic [DATA_WIDTH/8-1:0]       PSTRB,
    output logic                          PREADY,
    output logic [DATA_WIDTH-1:0]         PRDATA,
    output logic                          PSLVERR,
    output logic [SLV_CNT-1:0]            M_PSEL,
    output logic [SLV_ADDR_WIDTH-1:0]     M_PADDR,
    output logic                          M_PENABLE,
    output logic                          M_PWRITE,
    output logic [DATA_WIDTH-1:0]         M_PWDATA,
    output logic [DATA_WIDTH/8-1:0]       M_PSTRB,
    input  logic [SLV_CNT-1:0]            M_PREADY,
    input  logic [SLV_CNT*DATA_WIDTH-1:0] M_PRDATA,
    input  logic [SLV_CNT-1:0]            M_PSLVERR,
    output logic                          ERR_VALID,
    output logic [1:0]                    ERR_CODE,
    output logic [ADDR_WIDTH-1:0]         ERR_ADDR,
    input  logic                          ERR_CLR
);

    localparam int         IDX_W    = idx_width(SLV_CNT);
    localparam int         UP_W     = ADDR_WIDTH - SLV_ADDR_WIDTH;
    localparam bit         TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TMO_LAST = 16'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] sel_idx_reg, sel_idx_next;
    logic [15:0]      cnt_reg, cnt_next;

    logic [UP_W-1:0]       addr_upper;
    logic [IDX_W-1:0]      addr_idx;
    logic                  in_range;
    logic                  setup;
    logic                  slv_ready;
    logic                  slv_err;
    logic [DATA_WIDTH-1:0] slv_rdata;
    logic                  rsp_ready;
    logic                  rsp_err;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  penable_fwd;
    logic                  log_capture;
    logic [1:0]            log_code;
    logic                  sel_active;
    logic [IDX_W-1:0]      cur_idx;

    assign addr_upper = PADDR[ADDR_WIDTH-1:SLV_ADDR_WIDTH];
    assign addr_idx   = PADDR[SLV_ADDR_WIDTH +: IDX_W];
    assign in_range   = 32'(addr_upper) < SLV_CNT;
    assign setup      = PSEL && !PENABLE;

    always_comb begin
        slv_ready = 1'b0;
        slv_err   = 1'b0;
        slv_rdata = '0;
        for (int i = 0; i < SLV_CNT; i++) begin
            if (32'(sel_idx_reg) == i) begin
                slv_ready = M_PREADY[i];
                slv_err   = M_PSLVERR[i];
                slv_rdata = M_PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        sel_idx_next = sel_idx_reg;
        cnt_next     = cnt_reg;
        rsp_ready    = 1'b0;
        rsp_err      = 1'b0;
        rsp_rdata    = '0;
        penable_fwd  = 1'b0;
        log_capture  = 1'b0;
        log_code     = ERR_NONE;
        case (state_reg)
            IDLE: begin
                if (setup) begin
                    sel_idx_next = addr_idx;
                    cnt_next     = '0;
                    state_next   = in_range ? ACCESS : DECERR;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_next = IDLE;
                end else begin
                    penable_fwd = PENABLE;
                    if (PENABLE) begin
                        rsp_ready = slv_ready;
                        rsp_err   = slv_err;
                        rsp_rdata = slv_rdata;
                        if (slv_ready) begin
                            state_next  = IDLE;
                            log_capture = slv_err;
                            log_code    = ERR_SLV;
                        end else begin
                            cnt_next = cnt_reg + 16'd1;
                            if (TMO_EN && cnt_reg == TMO_LAST) begin
                                state_next = ABORT;
                            end
                        end
                    end
                end
            end
            DECERR: begin
                if (!PSEL) begin
                    state_next = IDLE;
                end else if (PENABLE) begin
                    rsp_ready   = 1'b1;
                    rsp_err     = 1'b1;
                    state_next  = IDLE;
                    log_capture = 1'b1;
                    log_code    = ERR_DEC;
                end
            end
            ABORT: begin
                state_next = IDLE;
                if (PSEL) begin
                    rsp_ready   = 1'b1;
                    rsp_err     = 1'b1;
                    log_capture = 1'b1;
                    log_code    = ERR_TMO;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg   <= IDLE;
            sel_idx_reg <= '0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            sel_idx_reg <= sel_idx_next;
            cnt_reg     <= cnt_next;
        end
    end

    // Setup decodes straight from PADDR so the slave sees PSEL in the same cycle as the master.
    always_comb begin
        sel_active = 1'b0;
        cur_idx    = sel_idx_reg;
        if (state_reg == IDLE && setup && in_range) begin
            sel_active = 1'b1;
            cur_idx    = addr_idx;
        end else if (state_reg == ACCESS && PSEL) begin
            sel_active = 1'b1;
        end
    end

    for (genvar gi = 0; gi < SLV_CNT; gi++) begin : g_psel
        assign M_PSEL[gi] = PRESETn && sel_active && (32'(cur_idx) == gi);
    end

    assign M_PENABLE = PRESETn && penable_fwd;
    assign M_PADDR   = PADDR[SLV_ADDR_WIDTH-1:0];
    assign M_PWRITE  = PWRITE;
    assign M_PWDATA  = PWDATA;
    assign M_PSTRB   = PSTRB;

    assign PREADY  = PRESETn && PSEL && rsp_ready;
    assign PSLVERR = PRESETn && PSEL && rsp_err;
    assign PRDATA  = (PRESETn && PSEL) ? rsp_rdata : '0;

    apb_err_log #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_err_log (
        .clk       (PCLK),
        .rst_n     (PRESETn),
        .clr       (ERR_CLR),
        .capture   (log_capture),
        .code      (log_code),
        .addr      (PADDR),
        .err_valid (ERR_VALID),
        .err_code  (ERR_CODE),
        .err_addr  (ERR_ADDR)
    );

endmodule

// File: tb/tb_apb_slave_mux.sv
// Table-driven plus randomized transaction-level check of apb_slave_mux.
module tb_apb_slave_mux;

    localparam int DW  = 32;
    localparam int AW  = 12;
    localparam int SAW = 8;
    localparam int NS  = 4;
    localparam int TMO = 16;

    logic              PCLK = 1'b0;
    logic              PRESETn = 1'b0;
    logic [AW-1:0]     PADDR = '0;
    logic              PSEL = 1'b0;
    logic              PENABLE = 1'b0;
    logic              PWRITE = 1'b0;
    logic [DW-1:0]     PWDATA = '0;
    logic [DW/8-1:0]   PSTRB = '0;
    logic              PREADY;
    logic [DW-1:0]     PRDATA;
    logic              PSLVERR;
    logic [NS-1:0]     M_PSEL;
    logic [SAW-1:0]    M_PADDR;
    logic              M_PENABLE;
    logic              M_PWRITE;
    logic [DW-1:0]     M_PWDATA;
    logic [DW/8-1:0]   M_PSTRB;
    logic [NS-1:0]     M_PREADY = '0;
    logic [NS*DW-1:0]  M_PRDATA = '0;
    logic [NS-1:0]     M_PSLVERR = '0;
    logic              ERR_VALID;
    logic [1:0]        ERR_CODE;
    logic [AW-1:0]     ERR_ADDR;
    logic              ERR_CLR = 1'b0;

    apb_slave_mux #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLV_ADDR_WIDTH(SAW),
        .SLV_CNT(NS), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA),
        .PSLVERR(PSLVERR), .M_PSEL(M_PSEL), .M_PADDR(M_PADDR), .M_PENABLE(M_PENABLE),
        .M_PWRITE(M_PWRITE), .M_PWDATA(M_PWDATA), .M_PSTRB(M_PSTRB), .M_PREADY(M_PREADY),
        .M_PRDATA(M_PRDATA), .M_PSLVERR(M_PSLVERR), .ERR_VALID(ERR_VALID),
        .ERR_CODE(ERR_CODE), .ERR_ADDR(ERR_ADDR), .ERR_CLR(ERR_CLR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] rdata;
        logic          slverr;
        logic          clr;
        logic [NS-1:0] e_psel;
        int            e_cycles;
        logic          e_abort;
        logic          e_pslverr;
        logic [DW-1:0] e_prdata;
        logic          e_ev;
        logic [1:0]    e_code;
        logic [AW-1:0] e_eaddr;
    } vec_t;

    int            n_vec = 0;
    int            n_err = 0;
    logic          exp_ev = 1'b0;
    logic [1:0]    exp_code = 2'b00;
    logic [AW-1:0] exp_addr = '0;
    vec_t          tbl[12];
    vec_t          v;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [AW-1:0] addr, logic wr, logic [DW-1:0] wdata, int waits,
                                logic [DW-1:0] rdata, logic slverr, logic clr, logic [NS-1:0] e_psel,
                                int e_cycles, logic e_abort, logic e_pslverr, logic [DW-1:0] e_prdata,
                                logic e_ev, logic [1:0] e_code, logic [AW-1:0] e_eaddr);
        vec_t r;
        r.addr = addr; r.wr = wr; r.wdata = wdata; r.waits = waits; r.rdata = rdata;
        r.slverr = slverr; r.clr = clr; r.e_psel = e_psel; r.e_cycles = e_cycles;
        r.e_abort = e_abort; r.e_pslverr = e_pslverr; r.e_prdata = e_prdata;
        r.e_ev = e_ev; r.e_code = e_code; r.e_eaddr = e_eaddr;
        return r;
    endfunction

    // Transaction-level reference: outcome of a whole transfer from decode, wait count and the error rules.
    function automatic vec_t model(vec_t in_v);
        vec_t       r;
        int         idx;
        logic       newerr;
        logic [1:0] code;
        r = in_v;
        idx = int'(in_v.addr[AW-1:SAW]);
        newerr = 1'b0;
        code = 2'b00;
        r.e_psel = '0;
        r.e_abort = 1'b0;
        r.e_cycles = 0;
        if (idx >= NS) begin
            r.e_pslverr = 1'b1; r.e_prdata = '0; newerr = 1'b1; code = 2'b01;
        end else begin
            r.e_psel = NS'(1 << idx);
            if (TMO != 0 && in_v.waits >= TMO) begin
                r.e_cycles = TMO; r.e_abort = 1'b1; r.e_pslverr = 1'b1; r.e_prdata = '0;
                newerr = 1'b1; code = 2'b10;
            end else begin
                r.e_cycles = in_v.waits; r.e_pslverr = in_v.slverr; r.e_prdata = in_v.rdata;
                newerr = in_v.slverr; code = 2'b11;
            end
        end
        if (in_v.clr) begin
            r.e_ev = 1'b0; r.e_code = 2'b00; r.e_eaddr = '0;
        end else if (newerr && !exp_ev) begin
            r.e_ev = 1'b1; r.e_code = code; r.e_eaddr = in_v.addr;
        end else begin
            r.e_ev = exp_ev; r.e_code = exp_code; r.e_eaddr = exp_addr;
        end
        return r;
    endfunction

    // Unselected slaves get random responses so any leakage through the mux shows up.
    task automatic drive_slaves(input int sel, input logic rdy, input logic [DW-1:0] rdata, input logic err);
        for (int i = 0; i < NS; i++) begin
            M_PREADY[i]  = 1'($urandom_range(0, 1));
            M_PSLVERR[i] = 1'($urandom_range(0, 1));
            M_PRDATA[i*DW +: DW] = $urandom;
        end
        if (sel < NS) begin
            M_PREADY[sel]  = rdy;
            M_PSLVERR[sel] = err;
            M_PRDATA[sel*DW +: DW] = rdata;
        end
    endtask

    task automatic chk_err_rec(input string tag);
        chk({tag, "_err_valid"}, ERR_VALID, exp_ev);
        chk({tag, "_err_code"}, ERR_CODE, exp_code);
        chk({tag, "_err_addr"}, ERR_ADDR, exp_addr);
    endtask

    task automatic xfer(input vec_t t, input bit idle_after);
        int              sel;
        logic [DW/8-1:0] strb;
        sel  = int'(t.addr[AW-1:SAW]);
        strb = 4'($urandom);
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = t.addr; PWRITE = t.wr;
        PWDATA = t.wdata; PSTRB = strb; ERR_CLR = 1'b0;
        drive_slaves(sel, 1'($urandom_range(0, 1)), $urandom, 1'b0);
        @(negedge PCLK);
        chk("setup_psel", M_PSEL, t.e_psel);
        chk("setup_penable", M_PENABLE, 0);
        chk("setup_pready", PREADY, 0);
        chk("m_paddr", M_PADDR, t.addr[SAW-1:0]);
        chk("m_pwdata", M_PWDATA, t.wdata);
        chk("m_pwrite", M_PWRITE, t.wr);
        chk("m_pstrb", M_PSTRB, strb);
        chk_err_rec("setup");
        @(posedge PCLK); #1;
        for (int k = 0; k <= t.e_cycles; k++) begin
            PENABLE = 1'b1;
            ERR_CLR = t.clr && (k == t.e_cycles);
            drive_slaves(sel, k >= t.waits, t.rdata, t.slverr);
            @(negedge PCLK);
            if (k < t.e_cycles) begin
                chk("wait_pready", PREADY, 0);
                chk("wait_psel", M_PSEL, t.e_psel);
                chk("wait_penable", M_PENABLE, 1);
            end else begin
                chk("done_pready", PREADY, 1);
                chk("done_pslverr", PSLVERR, t.e_pslverr);
                chk("done_prdata", PRDATA, t.e_prdata);
                chk("done_psel", M_PSEL, t.e_abort ? '0 : t.e_psel);
                chk("done_penable", M_PENABLE, (t.e_psel != 0) && !t.e_abort);
            end
            @(posedge PCLK); #1;
        end
        ERR_CLR = 1'b0;
        exp_ev = t.e_ev; exp_code = t.e_code; exp_addr = t.e_eaddr;
        $display("xfer addr=%03h wr=%0b waits=%0d clr=%0b -> pslverr=%0b prdata=%08h rec=%0b/%0d/%03h",
                 t.addr, t.wr, t.waits, t.clr, t.e_pslverr, t.e_prdata, exp_ev, exp_code, exp_addr);
        if (idle_after) begin
            PSEL = 1'b0; PENABLE = 1'b0;
            drive_slaves(NS, 1'b0, '0, 1'b0);
            @(negedge PCLK);
            chk("idle_pready", PREADY, 0);
            chk("idle_psel", M_PSEL, 0);
            chk_err_rec("idle");
            @(posedge PCLK); #1;
        end
    endtask

    task automatic rand_xfer(input bit idle_after);
        vec_t r;
        r = mk('0, 0, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, '0);
        r.addr   = {4'($urandom_range(0, 5)), 8'($urandom)};
        if ($urandom_range(0, 9) == 0) r.addr[AW-1:SAW] = 4'hF;
        r.wr     = 1'($urandom);
        r.wdata  = $urandom;
        r.waits  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 20)) : int'($urandom_range(0, 5));
        r.rdata  = $urandom;
        r.slverr = ($urandom_range(0, 4) == 0);
        r.clr    = ($urandom_range(0, 7) == 0);
        xfer(model(r), idle_after);
    endtask

    initial begin
        tbl[0]  = mk(12'h104, 1, 32'hDEADBEEF, 0,    32'h0,        0, 0, 4'b0010, 0,  0, 0, 32'h0,        0, 2'b00, 12'h000);
        tbl[1]  = mk(12'h308, 0, 32'h0,        3,    32'h12345678, 0, 0, 4'b1000, 3,  0, 0, 32'h12345678, 0, 2'b00, 12'h000);
        tbl[2]  = mk(12'h500, 0, 32'h0,        0,    32'h0,        0, 0, 4'b0000, 0,  0, 1, 32'h0,        1, 2'b01, 12'h500);
        tbl[3]  = mk(12'h200, 0, 32'h0,        16,   32'hCAFEF00D, 0, 0, 4'b0100, 16, 1, 1, 32'h0,        1, 2'b01, 12'h500);
        tbl[4]  = mk(12'h0FC, 0, 32'h0,        2,    32'hA5A5A5A5, 0, 1, 4'b0001, 2,  0, 0, 32'hA5A5A5A5, 0, 2'b00, 12'h000);
        tbl[5]  = mk(12'h2A0, 0, 32'h0,        1000, 32'h0,        0, 0, 4'b0100, 16, 1, 1, 32'h0,        1, 2'b10, 12'h2A0);
        tbl[6]  = mk(12'h044, 1, 32'h11223344, 0,    32'h0,        0, 1, 4'b0001, 0,  0, 0, 32'h0,        0, 2'b00, 12'h000);
        tbl[7]  = mk(12'h010, 0, 32'h0,        1,    32'h0BADF00D, 1, 0, 4'b0001, 1,  0, 1, 32'h0BADF00D, 1, 2'b11, 12'h010);
        tbl[8]  = mk(12'h2F0, 1, 32'h55AA55AA, 0,    32'h0,        0, 1, 4'b0100, 0,  0, 0, 32'h0,        0, 2'b00, 12'h000);
        tbl[9]  = mk(12'h1F0, 0, 32'h0,        0,    32'h600DD00D, 1, 1, 4'b0010, 0,  0, 1, 32'h600DD00D, 0, 2'b00, 12'h000);
        tbl[10] = mk(12'hF00, 1, 32'hFFFFFFFF, 0,    32'h0,        0, 0, 4'b0000, 0,  0, 1, 32'h0,        1, 2'b01, 12'hF00);
        tbl[11] = mk(12'h3FF, 0, 32'h0,        15,   32'h87654321, 0, 0, 4'b1000, 15, 0, 0, 32'h87654321, 1, 2'b01, 12'hF00);

        // A setup presented during reset must not reach any slave.
        PSEL = 1'b1; PADDR = 12'h100;
        #12;
        chk("rst_psel", M_PSEL, 0);
        chk("rst_penable", M_PENABLE, 0);
        chk("rst_pready", PREADY, 0);
        chk_err_rec("rst");
        PSEL = 1'b0;
        #1 PRESETn = 1'b1;
        @(posedge PCLK); #1;

        for (int i = 0; i < 12; i++) begin
            xfer(tbl[i], (i % 2) == 0);
        end

        // Idle-cycle clear.
        PSEL = 1'b0; PENABLE = 1'b0; ERR_CLR = 1'b1;
        @(posedge PCLK); #1;
        ERR_CLR = 1'b0;
        exp_ev = 1'b0; exp_code = 2'b00; exp_addr = '0;
        @(negedge PCLK);
        chk_err_rec("clr");
        @(posedge PCLK); #1;

        // PSEL dropped in the middle of an access: no error, next setup accepted straight away.
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 12'h220;
        drive_slaves(2, 1'b0, '0, 1'b0);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        drive_slaves(2, 1'b0, '0, 1'b0);
        @(negedge PCLK);
        chk("drop_wait_psel", M_PSEL, 4'b0100);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        chk("drop_pready", PREADY, 0);
        chk("drop_psel", M_PSEL, 0);
        @(posedge PCLK); #1;
        v = mk(12'h1C4, 0, 32'h0, 1, 32'h31415926, 0, 0, '0, 0, 0, 0, 0, 0, 0, '0);
        xfer(model(v), 1'b1);

        // Reset in the middle of an access on slave 1 with an error already logged.
        v = mk(12'h9AB, 0, 32'h0, 0, 32'h0, 0, 0, '0, 0, 0, 0, 0, 0, 0, '0);
        xfer(model(v), 1'b1);
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 12'h120;
        drive_slaves(1, 1'b0, '0, 1'b0);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        drive_slaves(1, 1'b0, '0, 1'b0);
        @(negedge PCLK);
        chk("pre_rst_psel", M_PSEL, 4'b0010);
        chk("pre_rst_err_valid", ERR_VALID, 1);
        #1 PRESETn = 1'b0;
        #1;
        chk("async_rst_psel", M_PSEL, 0);
        chk("async_rst_penable", M_PENABLE, 0);
        chk("async_rst_pready", PREADY, 0);
        chk("async_rst_err_valid", ERR_VALID, 0);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        PRESETn = 1'b1;
        exp_ev = 1'b0; exp_code = 2'b00; exp_addr = '0;
        @(posedge PCLK); #1;
        v = mk(12'h138, 1, 32'h0F0F0F0F, 2, 32'h0, 0, 0, '0, 0, 0, 0, 0, 0, 0, '0);
        xfer(model(v), 1'b0);

        for (int i = 0; i < 60; i++) begin
            rand_xfer(1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apb_slave_mux.md
Name: apb_slave_mux

Overview:
- Parametrised APB4 decoder/multiplexer between the bridge's APB master port and up to 16 downstream APB4 slaves.
- Decodes the slave index from the upper PADDR bits and forwards setup/access phases to the selected slave.
- Multiplexes the response back, and generates decode-error and timeout-error responses itself.
- Records the first error in a sticky status register for software/debug.

Parameters:
- DATA_WIDTH, 32: APB data width; multiple of 8.
- ADDR_WIDTH, 12: upstream PADDR width; must be >= SLV_ADDR_WIDTH + IDX_W.
- SLV_ADDR_WIDTH, 8: per-slave address window width (window size = 2^SLV_ADDR_WIDTH bytes).
- SLV_CNT, 4: number of downstream slaves, 1..16.
- TIMEOUT_CYCLES, 16: access-phase wait cycles before timeout abort; 0 disables the timeout; max 2^16-1.
- IDX_W (localparam): max(1, clog2(SLV_CNT)).

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  asynchronous active-low reset
- PADDR  in  ADDR_WIDTH  upstream address
- PSEL  in  1  upstream select
- PENABLE  in  1  upstream enable
- PWRITE  in  1  upstream write
- PWDATA  in  DATA_WIDTH  upstream write data
- PSTRB  in  DATA_WIDTH/8  upstream write strobes
- PREADY  out  1  upstream ready
- PRDATA  out  DATA_WIDTH  upstream read data
- PSLVERR  out  1  upstream error
- M_PSEL  out  SLV_CNT  one-hot downstream select
- M_PADDR  out  SLV_ADDR_WIDTH  PADDR[SLV_ADDR_WIDTH-1:0], broadcast
- M_PENABLE  out  1  downstream enable
- M_PWRITE  out  1  broadcast
- M_PWDATA  out  DATA_WIDTH  broadcast
- M_PSTRB  out  DATA_WIDTH/8  broadcast
- M_PREADY  in  SLV_CNT  per-slave ready
- M_PRDATA  in  SLV_CNT*DATA_WIDTH  per-slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
- M_PSLVERR  in  SLV_CNT  per-slave error
- ERR_VALID  out  1  sticky error flag
- ERR_CODE  out  2  01 = decode error, 10 = timeout, 11 = slave PSLVERR
- ERR_ADDR  out  ADDR_WIDTH  address of the first recorded error
- ERR_CLR  in  1  synchronous clear of the error record

Behaviour:
- Slave index: idx = PADDR[ADDR_WIDTH-1:SLV_ADDR_WIDTH]. The access is out of range when idx >= SLV_CNT.
- FSM states: IDLE, ACCESS, DECERR, ABORT. Reset state is IDLE.
- IDLE:
  - On PSEL & !PENABLE (setup phase), latch sel_idx and the range flag.
  - In range: go to ACCESS and drive M_PSEL[idx]=1 combinationally in the same cycle (zero added latency).
  - Out of range: go to DECERR; M_PSEL stays all-zero.
- ACCESS:
  - M_PSEL[sel_idx]=1; M_PENABLE=PENABLE.
  - PREADY=M_PREADY[sel_idx], PRDATA=M_PRDATA[sel_idx], PSLVERR=M_PSLVERR[sel_idx]; these are gated to 0 while PENABLE=0.
  - On PENABLE & M_PREADY[sel_idx], return to IDLE. A back-to-back setup in the next cycle is accepted.
  - Timeout counter clears in setup and increments each access cycle with ready low.
  - When count == TIMEOUT_CYCLES-1 and ready is still low, go to ABORT.
- DECERR:
  - In the first PENABLE cycle, PREADY=1, PSLVERR=1, PRDATA=0 (exactly one cycle), then return to IDLE.
  - Writes have no downstream effect.
- ABORT (single cycle):
  - PREADY=1, PSLVERR=1, PRDATA=0, M_PSEL=0, M_PENABLE=0; then go to IDLE.
  - A slave PREADY arriving in the abort cycle is ignored.
- Outside ACCESS: M_PSEL=0 and M_PENABLE=0.
- PREADY, PSLVERR and PRDATA are 0 whenever PSEL=0.
- Error record:
  - Captures only when ERR_VALID=0: on a decode-error completion, an abort, or an ACCESS completion with PSLVERR=1.
  - ERR_ADDR = full PADDR.
  - If ERR_CLR is asserted in the same cycle as a new error, ERR_CLR wins and the new error is not recorded.
- SLV_CNT=1: idx width is 1 and any nonzero upper bits decode as an error.
- PSEL dropped mid-transfer (protocol violation): return to IDLE the next cycle, deassert all M_PSEL, no error recorded.
- Reset (asynchronous, any state): FSM IDLE, counter 0, ERR_VALID/ERR_CODE/ERR_ADDR 0, all downstream selects 0. Outputs are low immediately on reset assertion.

Decomposition:
- Package apb_mux_pkg:
  - state enum (IDLE/ACCESS/DECERR/ABORT)
  - ERR_CODE constants (ERR_NONE=00, ERR_DEC=01, ERR_TMO=10, ERR_SLV=11)
  - clog2 helper for IDX_W
- Sub-module apb_err_log: the sticky capture/clear register, reusable by the bridge.
- Response mux and FSM stay in the top module.

Test Plan:
- Write PADDR=0x104, PWDATA=0xDEADBEEF; slave 1 ready with no wait -> M_PSEL=0010 in the setup and access cycles; M_PADDR=0x04; PREADY after 2 cycles total; no error.
- Read PADDR=0x308; slave 3 inserts 3 wait states, then PRDATA=0x12345678 -> PRDATA=0x12345678 on the ready cycle; PSLVERR=0; M_PSEL[3] held for 5 cycles.
- Read PADDR=0x500 (idx 5 >= 4) -> all M_PSEL=0; PREADY=PSLVERR=1 in the access cycle; PRDATA=0; ERR_VALID=1, ERR_CODE=01, ERR_ADDR=0x500.
- Slave 2 never ready, TIMEOUT_CYCLES=16 -> abort at the 16th wait cycle with PREADY=PSLVERR=1; M_PSEL=0 the same cycle; ERR_CODE stays 01 (first error kept); after ERR_CLR, repeating gives ERR_CODE=10.
- Slave 0 returns PSLVERR=1 with ERR_VALID=0 -> PSLVERR passed through; ERR_CODE=11; ERR_CLR and a new error in the same cycle -> ERR_VALID=0.
- PRESETn asserted mid-ACCESS on slave 1 -> M_PSEL=0 and ERR_VALID=0 asynchronously; a following transfer completes normally.
